// File: rtl/filt_out_decim_pkg.sv
// Shared constants and types for the filter output decimator.
// Optional drop counter is enabled by defining FILT_DECIM_DROP_CNT_EN.
package filt_out_decim_pkg;

  localparam int NB_DATA_DEF    = 8;
  localparam int DECIM_LOG2_DEF = 2;
  localparam int DECIM_LOG2_MIN = 1;
  localparam int DECIM_LOG2_MAX = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // Frame phase is derived from the frame counter, not stored.
  typedef enum logic {
    PH_ACCUM = 1'b0,
    PH_DUMP  = 1'b1
  } phase_e;

endpackage

// File: rtl/filt_out_decim_sync_fifo.sv
// Single-clock show-ahead FIFO; head entry is always visible on o_data.
module filt_out_decim_sync_fifo
  import filt_out_decim_pkg::*;
#(
  parameter int WIDTH = NB_DATA_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             wr_en;
  logic             rd_en;

  assign o_empty = (level == '0);
  assign o_full  = (level == LVL_W'(DEPTH));
  assign o_level = level;
  assign rd_en   = i_pop & ~o_empty;
  // A push into a full FIFO is only legal when a pop frees a slot on the same edge.
  assign wr_en   = i_push & (~o_full | rd_en);
  assign o_data  = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/filt_out_decim.sv
// Accumulate-and-dump decimator (factor 2**DECIM_LOG2) feeding a show-ahead output FIFO.
// Define FILT_DECIM_DROP_CNT_EN to add the saturating o_drop_cnt port.
module filt_out_decim
  import filt_out_decim_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clock,
  input  logic                          i_rst,
  input  logic [NB_DATA-1:0]            i_y,
  input  logic                          i_y_valid,
  output logic [NB_DATA-1:0]            o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_drop,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
`ifdef FILT_DECIM_DROP_CNT_EN
  ,
  output logic [7:0]                    o_drop_cnt
`endif
);

  localparam int ACC_W = NB_DATA + DECIM_LOG2;
  localparam int CNT_W = DECIM_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt;
  logic [NB_DATA-1:0]      avg;
  logic [DECIM_LOG2-1:0]   sum_frac_unused;
  phase_e                  phase;
  logic                    dump;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic                    fifo_full;

  assign phase = (cnt == CNT_LAST) ? PH_DUMP : PH_ACCUM;
  assign sum   = acc + {{DECIM_LOG2{i_y[NB_DATA-1]}}, i_y};
  // Dropping the low bits of the sign-extended sum is the floor-toward-minus-infinity shift;
  // the remaining NB_DATA bits always hold the average without wrap.
  assign {avg, sum_frac_unused} = sum;

  assign dump    = i_y_valid & (phase == PH_DUMP);
  assign o_valid = ~fifo_empty;
  assign pop     = o_valid & i_ready;
  assign push    = dump & (~fifo_full | pop);
  assign o_drop  = dump & fifo_full & ~pop;

  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (i_y_valid) begin
      if (phase == PH_DUMP) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  filt_out_decim_sync_fifo #(
    .WIDTH (NB_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (avg),
    .i_pop   (pop),
    .o_data  (o_data),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_level (o_level)
  );

`ifdef FILT_DECIM_DROP_CNT_EN
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      o_drop_cnt <= '0;
    end else if (o_drop && (o_drop_cnt != 8'hFF)) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_filt_out_decim.sv
// Bench for filt_out_decim: frame/queue model plus directed literal checks.
module tb_filt_out_decim;

  localparam int NF    = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_y = '0;
  logic       i_y_valid = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic       o_drop;
  logic [2:0] o_level;
  logic [7:0] o_drop_cnt;

  int total = 0;
  int bad = 0;
  int drop_seen = 0;

  int frame[$];
  int mq[$];
  int popped[$];
  int m_sum;
  int m_avg;
  bit m_pop;
  bit m_full;
  bit exp_drop;

  filt_out_decim dut (
    .clock     (clock),
    .i_rst     (i_rst),
    .i_y       (i_y),
    .i_y_valid (i_y_valid),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_drop    (o_drop),
    .o_level   (o_level)
`ifdef FILT_DECIM_DROP_CNT_EN
    ,
    .o_drop_cnt(o_drop_cnt)
`endif
  );

`ifndef FILT_DECIM_DROP_CNT_EN
  assign o_drop_cnt = '0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int floor_div(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Model: gather NF valid samples per frame, average with floor, bounded output queue.
  always @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      frame.delete();
      mq.delete();
    end else begin
      m_pop  = (mq.size() > 0) && i_ready;
      m_full = (mq.size() == DEPTH);
      if (m_pop) popped.push_back(mq.pop_front());
      if (i_y_valid) begin
        frame.push_back(int'($signed(i_y)));
        if (frame.size() == NF) begin
          m_sum = 0;
          foreach (frame[k]) m_sum += frame[k];
          m_avg = floor_div(m_sum, NF);
          frame.delete();
          if (!m_full || m_pop) mq.push_back(m_avg);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (i_rst) begin
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_level", int'(o_level), 0);
      chk("rst_drop", int'(o_drop), 0);
      chk("rst_data", int'(o_data), 0);
    end else begin
      exp_drop = i_y_valid && (frame.size() == NF - 1) && (mq.size() == DEPTH) && !i_ready;
      chk("cyc_valid", int'(o_valid), (mq.size() > 0) ? 1 : 0);
      chk("cyc_level", int'(o_level), mq.size());
      chk("cyc_drop", int'(o_drop), exp_drop ? 1 : 0);
      if (mq.size() > 0) chk("cyc_data", int'($signed(o_data)), mq[0]);
      if (o_drop) drop_seen++;
    end
  end

  task automatic step(input int v, input bit vld);
    i_y = v[7:0];
    i_y_valid = vld;
    @(posedge clock);
    #1;
    i_y_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1;
    idle(3);
    i_rst = 1'b0;
    idle(1);

    // 1) basic frame, one-cycle latency
    i_ready = 1'b1;
    popped.delete();
    step(1, 1'b1); step(1, 1'b1); step(2, 1'b1);
    chk("t1_no_early", int'(o_valid), 0);
    step(5, 1'b1);
    chk("t1_valid", int'(o_valid), 1);
    chk("t1_data", int'($signed(o_data)), 2);
    idle(3);
    chk("t1_cnt", popped.size(), 1);
    chk("t1_pop", popped[0], 2);
    chk("t1_fall", int'(o_valid), 0);

    // 2) negative floor
    popped.delete();
    step(-1, 1'b1); step(-2, 1'b1); step(-3, 1'b1); step(-4, 1'b1);
    chk("t2_data", int'(o_data), 8'hFD);
    idle(2);
    chk("t2_pop", popped[0], -3);

    // 3) gaps between valid samples
    popped.delete();
    step(1, 1'b1); idle(3);
    step(1, 1'b1); idle(3);
    step(2, 1'b1); idle(3);
    chk("t3_no_early", int'(o_valid), 0);
    step(5, 1'b1);
    idle(4);
    chk("t3_cnt", popped.size(), 1);
    chk("t3_pop", popped[0], 2);

    // 5) extremes
    popped.delete();
    for (int i = 0; i < 4; i++) step(127, 1'b1);
    for (int i = 0; i < 4; i++) step(-128, 1'b1);
    idle(3);
    chk("t5_cnt", popped.size(), 2);
    chk("t5_max", popped[0], 127);
    chk("t5_min", popped[1], -128);

    // 4) fill, overflow drop, drain
    i_ready = 1'b0;
    popped.delete();
    drop_seen = 0;
    for (int f = 0; f < 4; f++) for (int i = 0; i < 4; i++) step(4, 1'b1);
    chk("t4_full_level", int'(o_level), 4);
    chk("t4_no_drop_yet", drop_seen, 0);
    for (int i = 0; i < 4; i++) step(4, 1'b1);
    idle(1);
    chk("t4_drop", drop_seen, 1);
    chk("t4_level_kept", int'(o_level), 4);
`ifdef FILT_DECIM_DROP_CNT_EN
    chk("t4_drop_cnt", int'(o_drop_cnt), 1);
`endif
    i_ready = 1'b1;
    idle(6);
    chk("t4_drain_cnt", popped.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_drain", popped[i], 4);
    chk("t4_empty", int'(o_valid), 0);

    // 6) reset mid-frame
    popped.delete();
    step(5, 1'b1); step(5, 1'b1);
    i_rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(o_valid), 0);
    chk("t6_rst_level", int'(o_level), 0);
    chk("t6_rst_data", int'(o_data), 0);
    @(posedge clock);
    #1;
    i_rst = 1'b0;
    step(1, 1'b1); step(1, 1'b1); step(2, 1'b1); step(5, 1'b1);
    chk("t6_data", int'($signed(o_data)), 2);
    idle(3);
    chk("t6_cnt", popped.size(), 1);
    chk("t6_pop", popped[0], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
